tt_dfd_arb_ffs_pipe: RTL and testbench
======================================

Name: tt_dfd_arb_ffs_pipe

Overview:
Parametrised, registered N-to-1 arbiter with data multiplexing, used wherever several debug/trace sources feed one sink.
- Replaces the purely combinational find-first-set selector.
- Adds runtime-selectable fixed-priority (LSB-first or MSB-first) or round-robin arbitration.
- Adds valid/ready handshakes on both sides and a single-entry output register.
- Adds multi-beat grant locking so a packet from one source is never interleaved.

Parameters:
- WIDTH, 8, number of requesters (>=2, need not be a power of 2).
- SIZE, max($clog2(WIDTH),1), width of encoded index.
- DATA_WIDTH, 32, payload width per requester.
- LOCK_EN, 1, 1 enables multi-beat locking via req_last_in; 0 treats every beat as last.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- mode_in  in  2  0=fixed LSB-first, 1=fixed MSB-first, 2=round-robin, 3=reserved (behaves as 0).
- req_valid_in  in  WIDTH  per-requester valid.
- req_data_in  in  WIDTH x DATA_WIDTH  per-requester payload.
- req_last_in  in  WIDTH  per-requester end-of-packet marker.
- req_ready_out  out  WIDTH  one-hot accept; beat i is transferred when req_valid_in[i] & req_ready_out[i].
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  sink accepts the beat.
- out_data  out  DATA_WIDTH  registered payload.
- out_idx  out  SIZE  registered binary index of the source.
- out_onehot  out  WIDTH  registered one-hot of the source.
- out_last  out  1  registered req_last of the beat.
- any_req  out  1  combinational OR of req_valid_in.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out_valid=0, out_data=0, out_idx=0, out_onehot=0, out_last=0.
  - rr_ptr=0, lock_active=0, lock_idx=0.
  - Reset mid-packet discards the lock and any held beat.
- Load condition: load = ~out_valid | out_ready. Arbitration occurs only when load=1; otherwise req_ready_out=0.
- Winner selection when load=1 and lock_active=0:
  - mode 0: lowest set index of req_valid_in.
  - mode 1: highest set index.
  - mode 2: first set index scanning upward from rr_ptr, wrapping from WIDTH-1 to 0.
- Winner selection when lock_active=1:
  - Winner is lock_idx if req_valid_in[lock_idx]=1; otherwise no grant that cycle (stall, others stay blocked).
  - mode_in is ignored while locked.
- Grant output: req_ready_out = onehot(winner) when load & any valid; else all zero. At most one bit is ever set.
- Capture on grant: out_valid<=1, out_data<=req_data_in[w], out_idx<=w, out_onehot<=onehot(w), out_last<=req_last_in[w] (forced 1 if LOCK_EN=0).
- Drain without new grant: when out_ready & out_valid and no grant, out_valid<=0. Data fields hold their last value.
- Latency: 1 cycle from accepted request to out_valid. Throughput: 1 beat/cycle with out_ready held high (simultaneous drain and load allowed).
- Round-robin pointer:
  - Updates only on a grant in mode 2: rr_ptr<=(w==WIDTH-1)?0:w+1.
  - Holds in modes 0/1 and during stalls.
- Lock (LOCK_EN=1):
  - Granted beat with last=0: lock_active<=1, lock_idx<=w.
  - Granted beat with last=1: lock_active<=0.
  - Single-beat packets never lock.
- Mode change takes effect on the next unlocked arbitration; no state is reset.
- req_valid_in is sampled only when load=1. Requesters must hold valid/data until ready (AXI-style); the block does not check this.

Test Plan:
- WIDTH=4, mode 0, req_valid=4'b1010, all last=1, out_ready=1 -> cycle 0 ready=4'b0010; cycle 1 out_idx=1, out_valid=1; cycle 1 ready=4'b1000; cycle 2 out_idx=3.
- Mode 1, req_valid=4'b0110 held -> ready=4'b0100 every cycle; out_idx=2 continuously (no fairness in fixed mode).
- Mode 2, req_valid=4'b1111 held, out_ready=1 -> out_idx sequence 0,1,2,3,0,1; rr_ptr wraps 3->0. With WIDTH=5 the sequence is 0..4,0.
- Backpressure: out_ready=0 with out_valid=1 -> req_ready_out=0, outputs stable for 10 cycles; out_ready=1 -> same-cycle new grant, next beat appears the cycle after.
- Lock: req0 sends 3 beats (last on 3rd) while req1 valid, mode 2 -> out_idx 0,0,0 then 1. Dropping req0 valid mid-packet stalls with no grant to req1 until req0 resumes.
- Async reset asserted mid-packet with out_valid=1 -> out_valid=0 and lock cleared immediately; after release, mode 2 grants start from index 0.

Source files
------------

// File: rtl/tt_dfd_arb_ffs_pipe.sv
// Registered N-to-1 arbiter with payload mux, valid/ready on both sides and
// multi-beat grant locking. Fixed LSB/MSB-first or round-robin selection.
module tt_dfd_arb_ffs_pipe #(
  parameter int WIDTH      = 8,
  parameter int SIZE       = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_EN    = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [1:0]                       mode_in,
  input  logic [WIDTH-1:0]                 req_valid_in,
  input  logic [WIDTH-1:0][DATA_WIDTH-1:0] req_data_in,
  input  logic [WIDTH-1:0]                 req_last_in,
  output logic [WIDTH-1:0]                 req_ready_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SIZE-1:0]                  out_idx,
  output logic [WIDTH-1:0]                 out_onehot,
  output logic                             out_last,
  output logic                             any_req
);

  logic [SIZE-1:0]  rr_ptr;
  logic [SIZE-1:0]  lock_idx;
  logic             lock_active;
  logic [SIZE-1:0]  win_idx;
  logic             win_found;
  logic [WIDTH-1:0] win_onehot;
  logic             win_last;
  logic             load;
  logic             grant;

  assign any_req = |req_valid_in;
  // The output register can take a new beat when empty or draining this cycle.
  assign load    = ~out_valid | out_ready;

  // Winner selection; loops run so that the preferred candidate is assigned last.
  always_comb begin : select
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    if (lock_active) begin
      // A locked packet owns the output; if its source pauses, nobody else gets in.
      win_found = req_valid_in[lock_idx];
      win_idx   = lock_idx;
    end else begin
      case (mode_in)
        2'd1: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (req_valid_in[SIZE'(i)]) begin
              win_found = 1'b1;
              win_idx   = SIZE'(i);
            end
          end
        end
        2'd2: begin
          for (int k = WIDTH - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= WIDTH) cand = cand - WIDTH;
            if (req_valid_in[SIZE'(cand)]) begin
              win_found = 1'b1;
              win_idx   = SIZE'(cand);
            end
          end
        end
        default: begin
          for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_valid_in[SIZE'(i)]) begin
              win_found = 1'b1;
              win_idx   = SIZE'(i);
            end
          end
        end
      endcase
    end
  end

  assign win_onehot    = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
  assign win_last      = (LOCK_EN != 0) ? req_last_in[win_idx] : 1'b1;
  assign grant         = load & win_found;
  assign req_ready_out = grant ? win_onehot : '0;

  // Single-entry output register: capture on grant, otherwise drain when accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_last   <= 1'b0;
    end else if (grant) begin
      out_valid  <= 1'b1;
      out_data   <= req_data_in[win_idx];
      out_idx    <= win_idx;
      out_onehot <= win_onehot;
      out_last   <= win_last;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the last winner, only on round-robin grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant && (mode_in == 2'd2)) begin
      rr_ptr <= (win_idx == SIZE'(WIDTH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Packet lock: held from a non-last beat until the last beat of that source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (grant) begin
      lock_active <= ~win_last;
      if (!win_last) lock_idx <= win_idx;
    end
  end

endmodule

// File: tb/tb_tt_dfd_arb_ffs_pipe.sv
module tb_tt_dfd_arb_ffs_pipe;
  localparam int W  = 5;
  localparam int DW = 16;
  localparam int SZ = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [1:0]             mode_in;
  logic [W-1:0]           req_valid_in;
  logic [W-1:0][DW-1:0]   req_data_in;
  logic [W-1:0]           req_last_in;
  logic [W-1:0]           req_ready_out;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          out_data;
  logic [SZ-1:0]          out_idx;
  logic [W-1:0]           out_onehot;
  logic                   out_last;
  logic                   any_req;

  tt_dfd_arb_ffs_pipe #(.WIDTH(W), .SIZE(SZ), .DATA_WIDTH(DW), .LOCK_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .mode_in(mode_in),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_last_in(req_last_in),
    .req_ready_out(req_ready_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_onehot(out_onehot),
    .out_last(out_last), .any_req(any_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_valid, m_last, m_lock;
  int            m_idx, m_lidx, m_rr;
  logic [DW-1:0] m_data;
  logic [W-1:0]  m_oh;
  int            exp_w;
  bit            exp_grant;
  logic [DW-1:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
    if (m_lock) return req_valid_in[m_lidx] ? m_lidx : -1;
    case (mode_in)
      2'd1: for (int i = W - 1; i >= 0; i--) if (req_valid_in[i]) return i;
      2'd2: for (int k = 0; k < W; k++) if (req_valid_in[(m_rr + k) % W]) return (m_rr + k) % W;
      default: for (int i = 0; i < W; i++) if (req_valid_in[i]) return i;
    endcase
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_last = 0; m_lock = 0; m_idx = 0; m_lidx = 0; m_rr = 0;
    m_data = '0; m_oh = '0;
  endtask

  // Called just after negedge with inputs set; checks, clocks, advances model.
  task automatic step();
    logic [W-1:0] er;
    bit           load;
    #1;
    load      = !m_valid || out_ready;
    exp_w     = pick();
    exp_grant = load && (exp_w >= 0);
    er = '0;
    if (exp_grant) er[exp_w] = 1'b1;
    check("ready", req_ready_out, er);
    check("any_req", any_req, |req_valid_in);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_idx", out_idx, m_idx);
    check("out_onehot", out_onehot, m_oh);
    check("out_last", out_last, m_last);
    @(posedge clk);
    if (exp_grant) begin
      m_valid = 1;
      m_data  = req_data_in[exp_w];
      m_idx   = exp_w;
      m_oh    = '0;
      m_oh[exp_w] = 1'b1;
      m_last  = req_last_in[exp_w];
      if (mode_in == 2'd2) m_rr = (exp_w + 1) % W;
      m_lock  = !m_last;
      m_lidx  = exp_w;
    end else if (out_ready && m_valid) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_onehot", out_onehot, 0);
    check("rst_last", out_last, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic new_beat(input int i, input bit last);
    req_valid_in[i] = 1'b1;
    req_data_in[i]  = DW'($urandom);
    req_last_in[i]  = last;
  endtask

  task automatic refresh();
    for (int i = 0; i < W; i++) begin
      if (exp_grant && exp_w == i) begin
        if ($urandom_range(1) == 1) new_beat(i, $urandom_range(2) != 0);
        else req_valid_in[i] = 1'b0;
      end else if (!req_valid_in[i] && $urandom_range(3) == 0) begin
        new_beat(i, $urandom_range(2) != 0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b1; mode_in = 2'd0; req_valid_in = '0; req_last_in = '1; out_ready = 1'b0;
    for (int i = 0; i < W; i++) req_data_in[i] = DW'(16'h100 + i);
    model_reset();
    #3;
    do_reset();

    // fixed LSB-first, two requesters
    mode_in = 2'd0; out_ready = 1'b1; req_valid_in = 5'b01010;
    step();
    check("t1_idx_a", out_idx, 1);
    check("t1_valid", out_valid, 1);
    req_valid_in[1] = 1'b0;
    step();
    check("t1_idx_b", out_idx, 3);
    req_valid_in[3] = 1'b0;
    step();

    // fixed MSB-first has no fairness
    mode_in = 2'd1; req_valid_in = 5'b00110;
    for (int n = 0; n < 4; n++) begin
      step();
      check("t2_idx", out_idx, 2);
    end

    // round-robin sweep and wrap
    mode_in = 2'd2; req_valid_in = '1;
    for (int n = 0; n < 7; n++) begin
      step();
      check("t3_rr_idx", out_idx, n % W);
    end

    // backpressure holds the output steady
    out_ready = 1'b0; mode_in = 2'd0;
    held = out_data;
    for (int n = 0; n < 10; n++) begin
      step();
      check("t4_hold", out_data, held);
    end
    out_ready = 1'b1;
    step();
    check("t4_resume", out_idx, 0);
    req_valid_in = '0;
    step();
    step();
    check("t4_drained", out_valid, 0);

    // packet lock with a mid-packet pause
    do_reset();
    mode_in = 2'd2; req_valid_in = '0;
    new_beat(1, 1'b1);
    new_beat(0, 1'b0);
    step();
    check("t5_b1", out_idx, 0);
    new_beat(0, 1'b0);
    step();
    check("t5_b2", out_idx, 0);
    req_valid_in[0] = 1'b0;
    for (int n = 0; n < 3; n++) step();
    check("t5_stall", out_valid, 0);
    new_beat(0, 1'b1);
    step();
    check("t5_b3", out_idx, 0);
    req_valid_in[0] = 1'b0;
    step();
    check("t5_other", out_idx, 1);
    req_valid_in = '0;
    step();

    // async reset mid-packet, then round-robin restarts at 0
    new_beat(1, 1'b1);
    new_beat(0, 1'b0);
    step();
    check("t6_pre", out_valid, 1);
    do_reset();
    req_valid_in = '1; req_last_in = '1;
    step();
    check("t6_first", out_idx, 0);
    step();
    check("t6_second", out_idx, 1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(31) == 0) mode_in = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      step();
      refresh();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
